// File: rtl/freepdk45_sram_pkg.sv
// Shared types and helpers for the parametrised FreePDK45 1rw1r SRAM model.
package freepdk45_sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int unsigned LANE_MAX = 64;

  function automatic logic lane_parity(input logic [LANE_MAX-1:0] lane);
    return ^lane;
  endfunction

  function automatic logic in_range(input logic [31:0] addr, input int unsigned num_words);
    return addr < num_words;
  endfunction

endpackage

// File: rtl/freepdk45_sram_1rw1r_param_if.sv
// Port bundle for the 1rw1r SRAM; pinj0/parity_err exist only with SRAM_PARITY_EN.
interface freepdk45_sram_1rw1r_param_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_WMASKS = 8
);

  logic                  ready;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  collision;
  logic                  addr_err;
`ifdef SRAM_PARITY_EN
  logic                  pinj0;
  logic                  parity_err;
`endif

  modport master (
`ifdef SRAM_PARITY_EN
    output pinj0,
    input  parity_err,
`endif
    input  ready, dout0, dout1, collision, addr_err,
    output csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

  modport slave (
`ifdef SRAM_PARITY_EN
    input  pinj0,
    output parity_err,
`endif
    output ready, dout0, dout1, collision, addr_err,
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

endinterface

// File: rtl/freepdk45_sram_clear_fsm.sv
// Power-up clear sequencer: walks every word once after reset, then raises ready.
module freepdk45_sram_clear_fsm
  import freepdk45_sram_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 20,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == LAST_PTR) begin
        state_d = READY;
        ready_d = 1'b1;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign clear_we   = (state_q == CLEAR);
  assign clear_addr = ptr_q;

endmodule

// File: rtl/freepdk45_sram_1rw1r_param.sv
// Behavioural 1rw1r SRAM with byte masks, read-first collision flag and range checks.
// Optional per-lane even parity with error injection under SRAM_PARITY_EN.
module freepdk45_sram_1rw1r_param
  import freepdk45_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 20,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int unsigned WRITE_SIZE = 8
) (
  input logic                         clk0,
  input logic                         rst0,
  freepdk45_sram_1rw1r_param_if.slave bus
);

  localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;

  logic                  ready;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;

  freepdk45_sram_clear_fsm #(
    .NUM_WORDS  (NUM_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk        (clk0),
    .rst        (rst0),
    .ready      (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  logic active, in0, in1, p0_en, p0_wr, p0_rd, p1_rd;
  logic [DATA_WIDTH-1:0] rd0_word, rd1_word;

  assign active   = ready & ~rst0;
  assign in0      = in_range(32'(bus.addr0), NUM_WORDS);
  assign in1      = in_range(32'(bus.addr1), NUM_WORDS);
  assign p0_en    = active & ~bus.csb0;
  assign p0_wr    = p0_en & ~bus.web0;
  assign p0_rd    = p0_en & bus.web0;
  assign p1_rd    = active & ~bus.csb1;
  assign rd0_word = in0 ? mem_q[bus.addr0] : '0;
  assign rd1_word = in1 ? mem_q[bus.addr1] : '0;

  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_word_d;

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] par_q [NUM_WORDS];
  logic [NUM_WMASKS-1:0] rd0_par, rd1_par, wr_par_d;
  logic                  bad0, bad1;

  assign rd0_par = in0 ? par_q[bus.addr0] : '0;
  assign rd1_par = in1 ? par_q[bus.addr1] : '0;
`endif

  // The clear sequencer and port 0 never overlap, since port 0 waits for ready.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = clear_addr;
    wr_word_d = '0;
`ifdef SRAM_PARITY_EN
    wr_par_d  = '0;
`endif
    if (clear_we && !rst0) begin
      wr_en_d = 1'b1;
    end else if (p0_wr && in0) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.addr0;
      wr_word_d = rd0_word;
`ifdef SRAM_PARITY_EN
      wr_par_d  = rd0_par;
`endif
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (bus.wmask0[i]) begin
          wr_word_d[i*WRITE_SIZE +: WRITE_SIZE] = bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
`ifdef SRAM_PARITY_EN
          wr_par_d[i] = lane_parity(LANE_MAX'(bus.din0[i*WRITE_SIZE +: WRITE_SIZE])) ^ bus.pinj0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_word_d;
`ifdef SRAM_PARITY_EN
      par_q[wr_addr_d] <= wr_par_d;
`endif
    end
  end

  logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic                  collision_q, collision_d, addr_err_q, addr_err_d;

`ifdef SRAM_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    bad0 = 1'b0;
    bad1 = 1'b0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (lane_parity(LANE_MAX'(rd0_word[i*WRITE_SIZE +: WRITE_SIZE])) != rd0_par[i]) bad0 = 1'b1;
      if (lane_parity(LANE_MAX'(rd1_word[i*WRITE_SIZE +: WRITE_SIZE])) != rd1_par[i]) bad1 = 1'b1;
    end
    parity_err_d = (p0_rd & bad0) | (p1_rd & bad1);
  end
`endif

  // Reads sample the array before this edge's write lands, giving read-first collisions.
  always_comb begin
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    if (p0_rd) dout0_d = rd0_word;
    if (p1_rd) dout1_d = rd1_word;
    collision_d = p0_wr & p1_rd & in0 & in1 & (bus.addr0 == bus.addr1);
    addr_err_d  = (p0_en & ~in0) | (p1_rd & ~in1);
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout0_q      <= '0;
      dout1_q      <= '0;
      collision_q  <= 1'b0;
      addr_err_q   <= 1'b0;
`ifdef SRAM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      dout0_q      <= dout0_d;
      dout1_q      <= dout1_d;
      collision_q  <= collision_d;
      addr_err_q   <= addr_err_d;
`ifdef SRAM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.ready     = ready;
  assign bus.dout0     = dout0_q;
  assign bus.dout1     = dout1_q;
  assign bus.collision = collision_q;
  assign bus.addr_err  = addr_err_q;
`ifdef SRAM_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_freepdk45_sram_1rw1r_param.sv
// Scoreboard bench for freepdk45_sram_1rw1r_param; parity cases run when SRAM_PARITY_EN is defined.
module tb_freepdk45_sram_1rw1r_param;

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;

  // Free-running clock, 10 time units per period
  always #5 clk0 = ~clk0;

  freepdk45_sram_1rw1r_param_if #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (5),
    .NUM_WMASKS (8)
  ) bus ();

  freepdk45_sram_1rw1r_param #(
    .DATA_WIDTH (64),
    .NUM_WORDS  (20),
    .ADDR_WIDTH (5),
    .WRITE_SIZE (8)
  ) dut (
    .clk0 (clk0),
    .rst0 (rst0),
    .bus  (bus.slave)
  );

  typedef struct {
    int unsigned cyc;
    string       name;
    bit          ready;
    bit          chk0;
    logic [63:0] d0;
    bit          chk1;
    logic [63:0] d1;
    bit          coll;
    bit          aerr;
    bit          perr;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] MW  = 64'hFFFF_FFFF_5566_7788;
  localparam logic [63:0] PV  = 64'h0123_4567_89AB_CDEF;

  function automatic exp_t mk(input string n, input bit rdy, input bit c0, input logic [63:0] d0,
                              input bit c1, input logic [63:0] d1, input bit coll, input bit aerr,
                              input bit perr);
    exp_t e;
    e.cyc   = 0;
    e.name  = n;
    e.ready = rdy;
    e.chk0  = c0;
    e.d0    = d0;
    e.chk1  = c1;
    e.d1    = d1;
    e.coll  = coll;
    e.aerr  = aerr;
    e.perr  = perr;
    return e;
  endfunction

  // Drives one cycle of inputs at the falling edge and queues the response due after the next rising edge
  task automatic applyStimulus(input logic rst, input logic c0, input logic w0, input logic [7:0] m,
                               input logic [4:0] a0, input logic [63:0] d, input logic c1,
                               input logic [4:0] a1, input logic pinj, input exp_t e);
    @(negedge clk0);
    rst0       = rst;
    bus.csb0   = c0;
    bus.web0   = w0;
    bus.wmask0 = m;
    bus.addr0  = a0;
    bus.din0   = d;
    bus.csb1   = c1;
    bus.addr1  = a1;
`ifdef SRAM_PARITY_EN
    bus.pinj0  = pinj;
`else
    if (pinj !== 1'b0) $display("[TB] note: pinj0 ignored in this build");
`endif
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic cmpBit(input string n, input string f, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0b expected %0b", n, f, got, want);
    end
  endtask

  task automatic cmpWord(input string n, input string f, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h", n, f, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpBit(e.name, "ready", bus.ready, e.ready);
    cmpBit(e.name, "collision", bus.collision, e.coll);
    cmpBit(e.name, "addr_err", bus.addr_err, e.aerr);
    if (e.chk0) cmpWord(e.name, "dout0", bus.dout0, e.d0);
    if (e.chk1) cmpWord(e.name, "dout1", bus.dout1, e.d1);
`ifdef SRAM_PARITY_EN
    cmpBit(e.name, "parity_err", bus.parity_err, e.perr);
`endif
  endtask

  // Monitor: just after each rising edge, compare every queued expectation due this cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk0);
      #1;
      cyc++;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    bus.csb0   = 1'b1;
    bus.web0   = 1'b1;
    bus.wmask0 = '0;
    bus.addr0  = '0;
    bus.din0   = '0;
    bus.csb1   = 1'b1;
    bus.addr1  = '0;
`ifdef SRAM_PARITY_EN
    bus.pinj0  = 1'b0;
`endif

    repeat (2) applyStimulus(1, 1, 1, 8'h00, 0, 0, 1, 0, 0, mk("reset", 0, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 1, 1, 8'h00, 0, 0, 1, 0, 0, mk("clear", i == 19, 1, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++)
      applyStimulus(0, 0, 1, 8'h00, 5'(k), 0, 0, 5'(19 - k), 0, mk("clr_rd", 1, 1, 0, 1, 0, 0, 0, 0));

    applyStimulus(0, 0, 0, 8'hFF, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, mk("mw_full", 1, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 8'h0F, 3, 64'h1122_3344_5566_7788, 1, 0, 0, mk("mw_part", 1, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 1, 8'h00, 3, 0, 0, 3, 0, mk("mw_rd", 1, 1, MW, 1, MW, 0, 0, 0));

    applyStimulus(0, 0, 0, 8'hFF, 7, 64'hA, 1, 0, 0, mk("col_w", 1, 1, MW, 1, MW, 0, 0, 0));
    applyStimulus(0, 0, 0, 8'hFF, 7, 64'hB, 0, 7, 0, mk("col", 1, 1, MW, 1, 64'hA, 1, 0, 0));
    applyStimulus(0, 0, 1, 8'h00, 7, 0, 0, 7, 0, mk("col_after", 1, 1, 64'hB, 1, 64'hB, 0, 0, 0));

    applyStimulus(0, 0, 0, 8'hFF, 25, 64'hDEAD, 1, 0, 0, mk("rng_w", 1, 1, 64'hB, 1, 64'hB, 0, 1, 0));
    applyStimulus(0, 1, 1, 8'h00, 0, 0, 0, 25, 0, mk("rng_rd", 1, 1, 64'hB, 1, 0, 0, 1, 0));
    applyStimulus(0, 1, 1, 8'h00, 0, 0, 1, 0, 0, mk("rng_idle", 1, 1, 64'hB, 1, 0, 0, 0, 0));
    applyStimulus(0, 0, 1, 8'h00, 3, 0, 0, 7, 0, mk("rng_keep", 1, 1, MW, 1, 64'hB, 0, 0, 0));

`ifdef SRAM_PARITY_EN
    applyStimulus(0, 0, 0, 8'hFF, 5, PV, 1, 0, 1, mk("par_inj_w", 1, 1, MW, 1, 64'hB, 0, 0, 0));
    applyStimulus(0, 0, 1, 8'h00, 5, 0, 1, 0, 0, mk("par_inj_rd", 1, 1, PV, 1, 64'hB, 0, 0, 1));
    applyStimulus(0, 1, 1, 8'h00, 0, 0, 1, 0, 0, mk("par_idle", 1, 1, PV, 1, 64'hB, 0, 0, 0));
    applyStimulus(0, 0, 0, 8'hFF, 5, PV, 1, 0, 0, mk("par_fix_w", 1, 1, PV, 1, 64'hB, 0, 0, 0));
    applyStimulus(0, 1, 1, 8'h00, 0, 0, 0, 5, 0, mk("par_fix_rd", 1, 1, PV, 1, PV, 0, 0, 0));
`endif

    // Reset with a write in flight, then reset again at clear cycle 10
    applyStimulus(1, 0, 0, 8'hFF, 3, 64'h5555, 1, 0, 0, mk("rst_mid", 0, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, 1, 8'h00, 0, 0, 1, 0, 0, mk("clear_a", 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (2) applyStimulus(1, 1, 1, 8'h00, 0, 0, 1, 0, 0, mk("rst_clr", 0, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 1, 1, 8'h00, 0, 0, 1, 0, 0, mk("clear_b", i == 19, 1, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      applyStimulus(0, 0, 1, 8'h00, 5'(k), 0, 0, 5'(k + 10), 0, mk("rclr_rd", 1, 1, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
